// File: rtl/ws2812_fade_source_pkg.sv
// Shared definitions for the WS2812 fade pattern source: FSM encoding and
// per-LED channel ordering of the emitted byte stream.
package ws2812_fade_source_pkg;

  typedef enum logic [1:0] {
    ST_GAP    = 2'd0,
    ST_SEND   = 2'd1,
    ST_TAIL   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  // Byte index within one LED: G first, then R, then B.
  localparam int CH_G       = 0;
  localparam int CH_R       = 1;
  localparam int CH_B       = 2;
  localparam int CH_PER_LED = 3;

endpackage

// File: rtl/ws2812_fade_source_fade_step.sv
// One fade step for a single brightness byte: move cur one count toward tgt,
// or draw a fresh target once cur has arrived.
module fade_step (
  input  logic [7:0] cur,
  input  logic [7:0] tgt,
  input  logic [7:0] random,
  output logic [7:0] cur_next,
  output logic [7:0] tgt_next,
  output logic       load
);

  // cur always moves toward tgt, so neither branch can wrap.
  always_comb begin
    cur_next = cur;
    tgt_next = tgt;
    load     = 1'b0;
    if (cur < tgt) begin
      cur_next = cur + 8'd1;
    end else if (cur > tgt) begin
      cur_next = cur - 8'd1;
    end else begin
      tgt_next = random;
      load     = 1'b1;
    end
  end

endmodule

// File: rtl/ws2812_fade_source.sv
// Frame sequencer feeding ws2812_output: emits cur[] once per frame, waits out
// the tailguard and gap, and fades cur[] toward tgt[] every FADE_DIV frames.
module ws2812_fade_source
  import ws2812_fade_source_pkg::*;
#(
  parameter int LED_COUNT  = 11,
  parameter int FADE_DIV   = 4,
  parameter int GAP_CYCLES = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] random,
  input  logic       data_request,
  output logic       trigger,
  output logic [7:0] data,
  output logic       more_data
);

  localparam int NBYTES = CH_PER_LED * LED_COUNT;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NBYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [7:0]       FDIV_LAST = 8'(FADE_DIV - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] idx, idx_next;
  logic [7:0]       fdiv, fdiv_next;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_next;

  logic [7:0] cur [NBYTES];
  logic [7:0] tgt [NBYTES];

  logic [7:0] upd_cur;
  logic [7:0] upd_tgt;
  logic       upd_load;
  logic       upd_en;

  fade_step u_fade_step (
    .cur      (cur[idx]),
    .tgt      (tgt[idx]),
    .random   (random),
    .cur_next (upd_cur),
    .tgt_next (upd_tgt),
    .load     (upd_load)
  );

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    fdiv_next    = fdiv;
    gap_cnt_next = gap_cnt;
    upd_en       = 1'b0;
    case (state)
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_next   = ST_SEND;
          idx_next     = '0;
          gap_cnt_next = '0;
        end else begin
          gap_cnt_next = gap_cnt + GAP_W'(1);
        end
      end
      ST_SEND: begin
        if (data_request) begin
          if (idx == IDX_LAST) begin
            state_next = ST_TAIL;
          end else begin
            idx_next = idx + IDX_W'(1);
          end
        end
      end
      ST_TAIL: begin
        // data_request here marks the end of the strip's latch tailguard.
        if (data_request) begin
          if (fdiv == FDIV_LAST) begin
            fdiv_next  = '0;
            idx_next   = '0;
            state_next = ST_UPDATE;
          end else begin
            fdiv_next  = fdiv + 8'd1;
            state_next = ST_GAP;
          end
        end
      end
      ST_UPDATE: begin
        upd_en = 1'b1;
        if (idx == IDX_LAST) begin
          state_next = ST_GAP;
        end else begin
          idx_next = idx + IDX_W'(1);
        end
      end
      default: state_next = ST_GAP;
    endcase
  end

  // Outputs are registered from the next state so they switch with it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_GAP;
      idx       <= '0;
      fdiv      <= '0;
      gap_cnt   <= '0;
      trigger   <= 1'b0;
      more_data <= 1'b0;
      data      <= 8'h00;
    end else begin
      state     <= state_next;
      idx       <= idx_next;
      fdiv      <= fdiv_next;
      gap_cnt   <= gap_cnt_next;
      trigger   <= (state_next == ST_SEND);
      more_data <= (state_next == ST_SEND);
      data      <= (state_next == ST_SEND) ? cur[idx_next] : 8'h00;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < NBYTES; i++) begin
        cur[i] <= 8'h00;
        tgt[i] <= 8'h00;
      end
    end else if (upd_en) begin
      cur[idx] <= upd_cur;
      if (upd_load) begin
        tgt[idx] <= upd_tgt;
      end
    end
  end

endmodule

// File: tb/tb_ws2812_fade_source.sv
// Bench for ws2812_fade_source: two instances (FADE_DIV 1 and 3) checked every
// cycle against a frame-level model, plus literal timing and fade expectations.
module tb_ws2812_fade_source;

  localparam int LEDS = 2;
  localparam int N    = 3 * LEDS;
  localparam int GAPC = 5;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] random = 8'h03;
  logic       req  [2];
  logic       trig [2];
  logic       md   [2];
  logic [7:0] data [2];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ws2812_fade_source #(
      .LED_COUNT  (LEDS),
      .FADE_DIV   ((g == 0) ? 1 : 3),
      .GAP_CYCLES (GAPC)
    ) u_dut (
      .CLK          (CLK),
      .RST          (RST),
      .random       (random),
      .data_request (req[g]),
      .trigger      (trig[g]),
      .data         (data[g]),
      .more_data    (md[g])
    );
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d]: got 0x%0h, expected 0x%0h at %0t", name, d, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {P_GAP, P_SEND, P_TAIL, P_UPD} phase_e;
  phase_e     ph     [2];
  int         gapn   [2];
  int         pos    [2];
  int         frames [2];
  logic [7:0] mcur   [2][N];
  logic [7:0] mtgt   [2][N];

  task automatic mfade(input int d, input int i, input logic [7:0] r);
    if (mcur[d][i] == mtgt[d][i]) mtgt[d][i] = r;
    else if (mtgt[d][i] > mcur[d][i]) mcur[d][i] = mcur[d][i] + 8'd1;
    else mcur[d][i] = mcur[d][i] - 8'd1;
  endtask

  initial begin
    forever begin
      @(posedge CLK or posedge RST);
      for (int d = 0; d < 2; d++) begin
        if (RST) begin
          ph[d] = P_GAP; gapn[d] = 0; pos[d] = 0; frames[d] = 0;
          for (int i = 0; i < N; i++) begin
            mcur[d][i] = 8'h00;
            mtgt[d][i] = 8'h00;
          end
        end else begin
          case (ph[d])
            P_GAP: begin
              gapn[d]++;
              if (gapn[d] == GAPC) begin ph[d] = P_SEND; pos[d] = 0; end
            end
            P_SEND: if (req[d]) begin
              pos[d]++;
              if (pos[d] == N) ph[d] = P_TAIL;
            end
            P_TAIL: if (req[d]) begin
              frames[d]++;
              if (frames[d] % ((d == 0) ? 1 : 3) == 0) begin ph[d] = P_UPD; pos[d] = 0; end
              else begin ph[d] = P_GAP; gapn[d] = 0; end
            end
            P_UPD: begin
              mfade(d, pos[d], random);
              pos[d]++;
              if (pos[d] == N) begin ph[d] = P_GAP; gapn[d] = 0; end
            end
            default: ph[d] = P_GAP;
          endcase
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       cap_en = 1'b1;
  logic [7:0] firsts0[$];
  logic [7:0] firsts1[$];
  logic       prev_trig [2];

  initial begin
    logic       e_t;
    logic [7:0] e_d;
    prev_trig[0] = 1'b0;
    prev_trig[1] = 1'b0;
    forever begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        e_t = (ph[d] == P_SEND);
        e_d = e_t ? mcur[d][pos[d]] : 8'h00;
        chk("trigger", d, trig[d], e_t);
        chk("more_data", d, md[d], e_t);
        chk("data", d, data[d], e_d);
        if (cap_en && trig[d] && !prev_trig[d]) begin
          if (d == 0) firsts0.push_back(data[d]);
          else        firsts1.push_back(data[d]);
        end
        prev_trig[d] = trig[d];
      end
    end
  end

  task automatic wait_trig(input int d, input logic val, input int lim, input string nm);
    int t;
    t = 0;
    while (trig[d] !== val && t < lim) begin
      @(negedge CLK);
      t++;
    end
    chk(nm, d, trig[d], val);
  endtask

  logic [7:0] exp0 [6]  = '{8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h03};
  logic [7:0] exp1 [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                            8'h01, 8'h01, 8'h01, 8'h02, 8'h02, 8'h02};

  // ---------------- stimulus ----------------
  initial begin
    req[0] = 1'b0;
    req[1] = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;

    for (int k = 1; k <= GAPC; k++) begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        chk("rise_time", d, trig[d], (k == GAPC));
        if (k == GAPC) begin
          chk("rise_more_data", d, md[d], 1'b1);
          chk("rise_data", d, data[d], 8'h00);
        end
      end
    end

    req[0] = 1'b1;
    req[1] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) begin
        chk("send_trigger", d, trig[d], (k < 5));
        chk("send_more_data", d, md[d], (k < 5));
      end
    end

    // Fixed target byte: fade progression is fully predictable.
    for (int c = 0; c < 800; c++) begin
      req[0] = 1'($urandom_range(0, 1));
      req[1] = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    cap_en = 1'b0;
    chk("fade1_frames", 0, (firsts0.size() >= 6), 1'b1);
    if (firsts0.size() >= 6)
      for (int k = 0; k < 6; k++) chk("fade1_first_byte", 0, firsts0[k], exp0[k]);
    chk("fade3_frames", 1, (firsts1.size() >= 12), 1'b1);
    if (firsts1.size() >= 12)
      for (int k = 0; k < 12; k++) chk("fade3_first_byte", 1, firsts1[k], exp1[k]);

    for (int c = 0; c < 4000; c++) begin
      random = 8'($urandom);
      req[0] = 1'($urandom_range(0, 1));
      req[1] = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end

    // Reset in the middle of a frame, three bytes in.
    req[1] = 1'b0;
    req[0] = 1'b1;
    wait_trig(0, 1'b0, 200, "wait_frame_end");
    @(negedge CLK);
    req[0] = 1'b0;
    wait_trig(0, 1'b1, 200, "wait_frame_start");
    req[0] = 1'b1;
    repeat (3) @(negedge CLK);
    req[0] = 1'b0;
    chk("pre_rst_trigger", 0, trig[0], 1'b1);
    RST = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_async_trigger", d, trig[d], 1'b0);
      chk("rst_async_more_data", d, md[d], 1'b0);
      chk("rst_async_data", d, data[d], 8'h00);
    end
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 1; k <= GAPC; k++) begin
      @(negedge CLK);
      for (int d = 0; d < 2; d++) chk("rst_rise_time", d, trig[d], (k == GAPC));
    end
    for (int d = 0; d < 2; d++) chk("rst_first_byte", d, data[d], 8'h00);

    repeat (4) @(negedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ws2812_fade_source.md
# ws2812_fade_source

Pattern source that sits directly upstream of `ws2812_output` and feeds it the byte stream for one LED strip frame. It holds a current and a target brightness byte per colour channel per LED and walks each current value one step toward its target. When a channel reaches its target, it draws a new target from an external random byte. It sequences frames over the trigger / more-data / data-request handshake, including the reset tailguard, and inserts a programmable gap between frames.

## Interface
Parameters:
- `LED_COUNT`, 11: LEDs in the chain; bytes per frame = 3*`LED_COUNT` (G, R, B order per LED).
- `FADE_DIV`, 4: frames per fade step; range 1..255.
- `GAP_CYCLES`, 1000: idle cycles between tailguard end and next frame; minimum 1.

Ports:
- `CLK` input 1: single clock; all logic on rising edge.
- `RST` input 1: asynchronous, active-high reset.
- `random` input 8: free-running random byte, sampled only when loading a target.
- `data_request` input 1: one-cycle pulse from `ws2812_output`; consumes the current byte (while `more_data`) or signals tailguard end (while in TAIL).
- `trigger` output 1: high while a frame is being emitted.
- `data` output 8: byte to transmit, valid while `more_data`.
- `more_data` output 1: a byte is available on `data`.

## Operation
- Storage: `cur[0..3*LED_COUNT-1]` and `tgt[0..3*LED_COUNT-1]`, 8 bits each. Byte index `i` = 3*led + channel (0=G, 1=R, 2=B).
- Other state: index `idx` (width clog2(3*LED_COUNT)), frame counter `fdiv` (8 bit), gap counter (width clog2(GAP_CYCLES+1)).
- FSM states:
  - GAP: `trigger`=0, `more_data`=0. Counts `GAP_CYCLES` cycles, then goes to SEND with `idx`=0.
  - SEND: `trigger`=1, `more_data`=1, `data`=`cur[idx]`. On `data_request`, `idx`++. If `data_request` arrives with `idx`=3*`LED_COUNT`-1, go to TAIL.
  - TAIL: `trigger`=0, `more_data`=0. Wait for `data_request` (tailguard end).
    - If `fdiv`=`FADE_DIV`-1: clear `fdiv`, set `idx`=0, go to UPDATE.
    - Otherwise: `fdiv`++, go to GAP.
  - UPDATE: `trigger`=0, `more_data`=0. Processes one byte per cycle at `idx`; after `idx`=3*`LED_COUNT`-1, goes to GAP.
- Fade rule per byte in UPDATE:
  - cur<tgt: cur+1.
  - cur>tgt: cur-1.
  - cur==tgt: tgt<=`random`, cur unchanged.
  - Arithmetic is 8-bit and never wraps, because cur always moves toward tgt.
- `data_request` in GAP or UPDATE is ignored.
- Reset: all `cur` and `tgt` = 0, `fdiv`=0, `idx`=0, gap counter=0, state=GAP. Outputs during and after reset: `trigger`=0, `more_data`=0, `data`=0.
- Consequence of reset values: the first UPDATE loads a random target into every byte, and all cur stay 0.

## Timing
- `data` is registered. It equals `cur[idx]` from the first SEND cycle and updates the cycle after each `data_request`. `ws2812_output` samples `data` in the cycle `data_request` is high.
- `trigger` and `more_data` are registered and change state together. The last `data_request` in SEND drops both on the next cycle.
- GAP lasts exactly `GAP_CYCLES` cycles from entry to the first SEND cycle.
- UPDATE lasts exactly 3*`LED_COUNT` cycles.
- Back-to-back `data_request` (every cycle) must be accepted; one byte is consumed per pulse.
- Reset asserted mid-SEND or mid-UPDATE aborts immediately. Partially updated `cur`/`tgt` are cleared, and no further bytes are offered until after a full GAP.

## Structure
- Shared package: state encoding (GAP, SEND, TAIL, UPDATE) and channel-order constants (G=0, R=1, B=2).
- Sub-module `fade_step`: combinational next-cur/next-tgt/load-flag from (cur, tgt, random), instantiated once on the UPDATE path.
- `cur`/`tgt` are plain register arrays, not inferred RAM. SEND and UPDATE use different addresses, and both need single-cycle read.

## Test plan
- Reset then idle, `LED_COUNT`=2, `GAP_CYCLES`=5 -> `trigger` rises exactly 5 cycles after `RST` falls, and `more_data`=1 with `data`=0x00.
- Pulse `data_request` 6 times in SEND -> exactly 6 bytes consumed; `trigger`/`more_data` fall the cycle after the 6th pulse.
- TAIL with `FADE_DIV`=1, `random` held at 0x03 -> first UPDATE sets all tgt=0x03. Subsequent frames emit cur values 0x01, 0x02, 0x03 on all bytes, then hold at 0x03.
- After targets are loaded with cur=0x80, tgt=0x7E -> cur decrements to 0x7F, then 0x7E, and a new target is loaded on the following step.
- `FADE_DIV`=3 -> cur changes only after every 3rd tailguard `data_request`.
- Assert `RST` during SEND at byte 3 -> all outputs are 0 next cycle, and the first byte of the new frame is 0x00.
